ex_muldiv_stage: RTL and testbench
==================================

EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 SHALL have the following ports, one per line (name  direction  width  meaning):
- clk  in  1  rising-edge clock for all state.
- reset  in  1  reset, synchronous, active-high.
- power  in  1  global enable; when low, all state holds.
- flush  in  1  synchronous abort of the in-flight mul/div.
- control  in  8  ID/EX control byte; bit0 alu_src_imm, bit1 reg_write, bit2 rtype; other bits pass through.
- func  in  6  R-type function field.
- read1  in  32  operand A.
- read2  in  32  register operand B.
- imm  in  32  sign-extended immediate.
- result  out  32  EX result.
- hi  out  32  HI register.
- lo  out  32  LO register.
- stall  out  1  holds the upstream pipeline registers.
- busy  out  1  iterative unit active.

Function
REQ-002 SHALL select opB = control[0] ? imm : read2.
REQ-003 SHALL decode the following func codes only when control[2]=1:
- ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed).
- MFHI 0x10, MFLO 0x12.
- MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
REQ-004 SHALL, when control[2]=0, compute result = read1 + opB, wrapping mod 2^32.
REQ-005 SHALL drive result combinationally for ALU ops, MFHI (hi) and MFLO (lo). MULT/DIV-class ops drive result 0.
REQ-006 SHALL implement FSM states IDLE, RUN and DONE.
REQ-007 SHALL, in IDLE with power=1, flush=0 and a MULT/DIV-class op present (issue cycle T):
- latch operand magnitudes, sign flags and op kind;
- clear the iteration counter;
- go to RUN.
REQ-008 SHALL perform exactly one iteration per RUN cycle over 32 RUN cycles (T+1..T+32):
- multiply: shift-add;
- divide: restoring.
REQ-009 SHALL write hi/lo at the edge ending cycle T+32, then enter DONE.
- Signed ops: apply two's-complement sign correction to product, quotient and remainder; remainder takes the dividend's sign.
REQ-010 SHALL assert stall in cycle T and in every RUN cycle (33 cycles total), and deassert it in DONE.
REQ-011 SHALL make DONE last one cycle and return to IDLE without re-issuing, even though the same instruction is still present at the inputs.
REQ-012 SHALL assert busy exactly while in RUN.
REQ-013 SHALL, for DIV/DIVU with divisor 0, produce hi = dividend and lo = 0xFFFFFFFF with the same latency.
REQ-014 SHALL, on flush in RUN or DONE:
- go to IDLE next cycle with stall=0;
- leave hi/lo unchanged.
- Flush in the issue cycle suppresses the issue.
REQ-015 SHALL freeze FSM, counter and hi/lo while power=0; stall holds its current value.
REQ-016 SHALL make MFHI/MFLO issued in the cycle after DONE observe the new hi/lo values.

Reset
REQ-017 SHALL, on reset at any clock edge (including mid-RUN), set:
- state IDLE, counter 0;
- hi=0, lo=0;
- stall=0, busy=0.
REQ-018 SHALL give reset priority over flush and power.

Structure
REQ-019 SHALL place the func-code constants, the FSM state encoding and the ITER=32 constant in shared package cpu_pkg.
REQ-020 SHALL implement the iterative datapath as one sub-module muldiv_iter with ports: start, kind, operands, done, hi/lo.
- The ALU, operand mux and stall logic stay in ex_muldiv_stage.

Verification
REQ-021 SHALL cover ADD, control=0x04, func=0x20, read1=5, read2=7 -> result=12, stall never high.
REQ-022 SHALL cover MULT, read1=0xFFFFFFFD (-3), read2=7:
- stall high for exactly 33 cycles;
- then hi=0xFFFFFFFF, lo=0xFFFFFFEB;
- a following MFLO returns 0xFFFFFFEB.
REQ-023 SHALL cover DIVU 100/7 -> lo=14, hi=2; DIV with read2=0 and read1=0x1234 -> hi=0x1234, lo=0xFFFFFFFF.
REQ-024 SHALL cover flush asserted at RUN cycle 10 of a MULTU -> stall=0 next cycle, hi/lo keep their prior values, FSM in IDLE.
REQ-025 SHALL cover reset mid-RUN -> next cycle hi=lo=0, stall=0, busy=0, and a subsequent MULTU 3*4 gives lo=12 after 33 stall cycles.
REQ-026 SHALL cover power=0 for 5 cycles mid-RUN -> total stall length extends by exactly 5 cycles and the result is unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared func codes, FSM encoding and mul/div constants
package cpu_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // bit1 selects divide, bit0 selects signed operation
    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_kind_t;

    function automatic logic is_md_func(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

    function automatic md_kind_t md_kind_of(input logic [5:0] f);
        return md_kind_t'({f[1], ~f[0]});
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - 32-step shift-add multiplier / restoring divider
module muldiv_iter
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    input  md_kind_t    kind,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // acc holds {partial product, multiplier} or {remainder, quotient}
    logic [63:0]      acc;
    logic [31:0]      opnd;
    logic             is_div;
    logic             neg_main;
    logic             neg_rem;
    logic             div0;
    logic [CNT_W-1:0] cnt;

    logic        sa, sb;
    logic [31:0] ma, mb;
    logic [32:0] mul_sum;
    logic [32:0] r_sh;
    logic [32:0] div_diff;
    logic [63:0] mul_next, div_next, acc_next;
    logic [63:0] prod;
    logic [31:0] q, r;

    always_comb begin
        sa = kind[0] & op_a[31];
        sb = kind[0] & op_b[31];
        ma = sa ? -op_a : op_a;
        mb = sb ? -op_b : op_b;

        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};

        r_sh     = {acc[63:32], acc[31]};
        div_diff = r_sh - {1'b0, opnd};
        div_next = div_diff[32] ? {r_sh[31:0], acc[30:0], 1'b0}
                                : {div_diff[31:0], acc[30:0], 1'b1};

        acc_next = is_div ? div_next : mul_next;

        // results reflect the step in progress so the last step can be captured directly
        prod = neg_main ? -acc_next : acc_next;
        q    = div0 ? 32'hFFFF_FFFF : (neg_main ? -acc_next[31:0] : acc_next[31:0]);
        r    = neg_rem ? -acc_next[63:32] : acc_next[63:32];
        hi   = is_div ? r : prod[63:32];
        lo   = is_div ? q : prod[31:0];
        done = (cnt == CNT_W'(ITER - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div0     <= 1'b0;
            cnt      <= '0;
        end else if (start) begin
            acc      <= {32'd0, kind[1] ? ma : mb};
            opnd     <= kind[1] ? mb : ma;
            is_div   <= kind[1];
            neg_main <= sa ^ sb;
            neg_rem  <= sa;
            div0     <= (op_b == 32'd0);
            cnt      <= '0;
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ex_muldiv_stage.sv
// rtl/ex_muldiv_stage.sv - EX stage ALU with iterative mul/div and HI/LO
module ex_muldiv_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        power,
    input  logic        flush,
    input  logic [7:0]  control,
    input  logic [5:0]  func,
    input  logic [31:0] read1,
    input  logic [31:0] read2,
    input  logic [31:0] imm,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    output logic        busy
);

    state_t      state;
    logic        stall_hold;
    logic [31:0] opb;
    logic        rtype;
    logic        md_op;
    logic        issue;
    logic        iter_step;
    logic        iter_done;
    logic [31:0] iter_hi, iter_lo;
    logic        stall_now;
    logic        unused_ctrl;

    assign unused_ctrl = ^{control[7:3], control[1]};

    assign opb       = control[0] ? imm : read2;
    assign rtype     = control[2];
    assign md_op     = rtype && is_md_func(func);
    assign issue     = (state == ST_IDLE) && power && !flush && md_op;
    assign iter_step = (state == ST_RUN) && power && !flush;
    assign stall_now = issue || (state == ST_RUN);
    // with power off nothing advances, so the last observed stall is replayed
    assign stall     = power ? stall_now : stall_hold;
    assign busy      = (state == ST_RUN);

    always_comb begin
        result = 32'd0;
        if (!rtype) begin
            result = read1 + opb;
        end else begin
            case (func)
                FN_ADD:  result = read1 + opb;
                FN_SUB:  result = read1 - opb;
                FN_AND:  result = read1 & opb;
                FN_OR:   result = read1 | opb;
                FN_SLT:  result = {31'd0, $signed(read1) < $signed(opb)};
                FN_MFHI: result = hi;
                FN_MFLO: result = lo;
                default: result = 32'd0;
            endcase
        end
    end

    muldiv_iter u_iter (
        .clk   (clk),
        .reset (reset),
        .start (issue),
        .step  (iter_step),
        .kind  (md_kind_of(func)),
        .op_a  (read1),
        .op_b  (opb),
        .done  (iter_done),
        .hi    (iter_hi),
        .lo    (iter_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hi         <= 32'd0;
            lo         <= 32'd0;
            stall_hold <= 1'b0;
        end else if (power) begin
            stall_hold <= stall_now;
            case (state)
                ST_IDLE: if (issue) state <= ST_RUN;
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (iter_done) begin
                        hi    <= iter_hi;
                        lo    <= iter_lo;
                        state <= ST_DONE;
                    end
                end
                // the instruction leaves the stage here; it must not be issued again
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb/tb_ex_muldiv_stage.sv - directed scoreboard bench for ex_muldiv_stage
module tb_ex_muldiv_stage;

    logic        clk = 1'b0;
    logic        reset, power, flush;
    logic [7:0]  control;
    logic [5:0]  func;
    logic [31:0] read1, read2, imm;
    logic [31:0] result, hi, lo;
    logic        stall, busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    ex_muldiv_stage dut (
        .clk     (clk),
        .reset   (reset),
        .power   (power),
        .flush   (flush),
        .control (control),
        .func    (func),
        .read1   (read1),
        .read2   (read2),
        .imm     (imm),
        .result  (result),
        .hi      (hi),
        .lo      (lo),
        .stall   (stall),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sq, sr;
        case (f)
            6'h18: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            6'h19: return {32'd0, a} * {32'd0, b};
            6'h1A: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            6'h1B: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic alu(input string tag, input logic [7:0] c, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(posedge clk); #1;
        control = c; func = f; read1 = a; read2 = b;
        @(negedge clk);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    endtask

    // issues one mul/div, counts stall cycles, optionally drops power for 5 cycles
    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int pwr_at, input int exp_stall);
        logic [63:0] e;
        int n;
        sb.push_back(md_model(f, a, b));
        @(posedge clk); #1;
        control = 8'h04; func = f; read1 = a; read2 = b;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            @(posedge clk); #1;
            power = !(pwr_at >= 0 && c + 1 >= pwr_at && c + 1 < pwr_at + 5);
        end
        power = 1'b1;
        chk({tag, "_stall_len"}, n, exp_stall);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, hi, e[63:32]);
            chk({tag, "_lo"}, lo, e[31:0]);
        end
    endtask

    initial begin
        reset = 1'b1; power = 1'b1; flush = 1'b0;
        control = 8'h00; func = 6'h00; read1 = 32'd0; read2 = 32'd0; imm = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        alu("add", 8'h04, 6'h20, 32'd5, 32'd7, 32'd12);
        alu("sub", 8'h04, 6'h22, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu("and", 8'h04, 6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        alu("or", 8'h04, 6'h25, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
        alu("slt", 8'h04, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu("slt_ge", 8'h04, 6'h2A, 32'd1, 32'hFFFF_FFFF, 32'd0);
        imm = 32'hFFFF_FFFD;
        alu("itype", 8'h01, 6'h18, 32'd10, 32'd99, 32'd7);
        imm = 32'd0;

        run_md("mult", 6'h18, 32'hFFFF_FFFD, 32'd7, -1, 33);
        alu("mflo", 8'h04, 6'h12, 32'd0, 32'd0, 32'hFFFF_FFEB);
        alu("mfhi", 8'h04, 6'h10, 32'd0, 32'd0, 32'hFFFF_FFFF);

        run_md("divu", 6'h1B, 32'd100, 32'd7, -1, 33);
        run_md("div_neg", 6'h1A, 32'hFFFF_FF9C, 32'd7, -1, 33);
        run_md("div0", 6'h1A, 32'h0000_1234, 32'd0, -1, 33);
        chk("div0_hi_const", hi, 32'h0000_1234);
        chk("div0_lo_const", lo, 32'hFFFF_FFFF);

        @(posedge clk); #1;
        control = 8'h04; func = 6'h18; read1 = 32'd9; read2 = 32'd9; flush = 1'b1;
        @(negedge clk);
        chk("flush_issue_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; control = 8'h00;
        @(negedge clk);
        chk("flush_issue_busy", {31'd0, busy}, 32'd0);

        @(posedge clk); #1;
        control = 8'h04; func = 6'h19; read1 = 32'd5; read2 = 32'd6;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_run_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; control = 8'h00;
        @(negedge clk);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", hi, 32'h0000_1234);
        chk("flush_lo", lo, 32'hFFFF_FFFF);

        @(posedge clk); #1;
        control = 8'h04; func = 6'h19; read1 = 32'd5; read2 = 32'd6;
        repeat (6) begin @(posedge clk); #1; end
        reset = 1'b1; control = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rrun_hi", hi, 32'd0);
        chk("rrun_lo", lo, 32'd0);
        chk("rrun_stall", {31'd0, stall}, 32'd0);
        chk("rrun_busy", {31'd0, busy}, 32'd0);
        run_md("multu_3x4", 6'h19, 32'd3, 32'd4, -1, 33);
        chk("multu_3x4_lo_const", lo, 32'd12);

        run_md("pwr", 6'h19, 32'h1234_5678, 32'h9ABC_DEF0, 10, 38);
        run_md("mult_minint", 6'h18, 32'h8000_0000, 32'hFFFF_FFFF, 4, 38);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
